// File: rtl/ps2_key_collector_if.sv
// Move bus between the PS/2 key collector (master) and the game controller (slave).
// Carries the collected key slots, their occupancy and the move valid/ack handshake.
interface ps2_key_collector_if #(
    parameter int NUM_KEYS = 4
);
    logic [8*NUM_KEYS-1:0] keys_out;
    logic [NUM_KEYS-1:0]   key_valid;
    logic [3:0]            key_count;
    logic                  move_valid;
    logic                  move_ack;

    modport master (
        output keys_out,
        output key_valid,
        output key_count,
        output move_valid,
        input  move_ack
    );

    modport slave (
        input  keys_out,
        input  key_valid,
        input  key_count,
        input  move_valid,
        output move_ack
    );
endinterface

// File: rtl/ps2_key_collector.sv
// Purpose: oversampled PS/2 receiver that collects NUM_KEYS released keys into a move buffer.
// Latency: byte_strobe 1 clk after the synchronised stop-bit edge; buffer updates 1 clk later.
// Backpressure: move_valid holds until move_ack; extra keys while full are dropped.
// Optional: define PS2_PARITY_CHECK_EN to reject frames whose data+parity is not odd.
module ps2_key_collector #(
    parameter int          NUM_KEYS    = 4,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [7:0]  BKSP_CODE   = 8'h66,
    parameter logic [7:0]  ESC_CODE    = 8'h76
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    ps2_key_collector_if.master    mv,
    output logic                   byte_strobe,
    output logic                   frame_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);
    localparam logic [3:0]      KEYS_FULL = 4'(NUM_KEYS);
    localparam logic [7:0]      BREAK_CODE = 8'hF0;
    localparam logic [7:0]      EXT_CODE   = 8'hE0;

    // ------------------------------------------------------------------
    // Input synchronisers; reset to the idle-high line level so no false
    // falling edge is seen as reset releases.
    // ------------------------------------------------------------------
    logic clk_s1, sync_clk, sync_clk_prev;
    logic dat_s1, sync_data;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1        <= 1'b1;
            sync_clk      <= 1'b1;
            sync_clk_prev <= 1'b1;
            dat_s1        <= 1'b1;
            sync_data     <= 1'b1;
        end else begin
            clk_s1        <= ps2_clk;
            sync_clk      <= clk_s1;
            sync_clk_prev <= sync_clk;
            dat_s1        <= ps2_data;
            sync_data     <= dat_s1;
        end
    end

    assign fall = sync_clk_prev & ~sync_clk;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    frame_state_t     state;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_byte;
    logic [TO_W-1:0]  to_cnt;
    logic             frame_good;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    // sync_data is the stop bit on the STOP-state edge
    assign frame_good = sync_data & (^{shift_reg, parity_bit});
`else
    assign frame_good = sync_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'd0;
            rx_byte     <= 8'd0;
            to_cnt      <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;

            if (fall || state == IDLE)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            if (state != IDLE && !fall && to_cnt == TO_MAX) begin
                // Stalled keyboard: drop the partial frame
                state     <= IDLE;
                shift_reg <= 8'd0;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!sync_data) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {sync_data, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= sync_data;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        if (frame_good) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Break tracking and move buffer
    // ------------------------------------------------------------------
    logic [8*NUM_KEYS-1:0] keys_r;
    logic [NUM_KEYS-1:0]   key_valid_r;
    logic [3:0]            key_count_r;
    logic                  move_valid_r;
    logic                  break_pending;
    logic                  released;
    logic                  ack_fire;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      del_idx;

    assign released = byte_strobe && break_pending &&
                      rx_byte != BREAK_CODE && rx_byte != EXT_CODE;
    assign ack_fire = move_valid_r & mv.move_ack;
    assign wr_idx   = IDX_W'(key_count_r);
    assign del_idx  = IDX_W'(key_count_r - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            break_pending <= 1'b0;
        end else if (byte_strobe) begin
            if (rx_byte == BREAK_CODE)
                break_pending <= 1'b1;
            else if (rx_byte != EXT_CODE)
                break_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_r       <= '0;
            key_valid_r  <= '0;
            key_count_r  <= 4'd0;
            move_valid_r <= 1'b0;
        end else begin
            // Full buffer raises move_valid one clock after the last key lands
            move_valid_r <= (key_count_r == KEYS_FULL);

            if (ack_fire) begin
                keys_r       <= '0;
                key_valid_r  <= '0;
                key_count_r  <= 4'd0;
                move_valid_r <= 1'b0;
            end else if (released) begin
                if (rx_byte == ESC_CODE) begin
                    keys_r       <= '0;
                    key_valid_r  <= '0;
                    key_count_r  <= 4'd0;
                    move_valid_r <= 1'b0;
                end else if (rx_byte == BKSP_CODE) begin
                    move_valid_r <= 1'b0;
                    if (key_count_r != 4'd0) begin
                        keys_r[8*del_idx +: 8] <= 8'd0;
                        key_valid_r[del_idx]   <= 1'b0;
                        key_count_r            <= key_count_r - 4'd1;
                    end
                end else if (key_count_r < KEYS_FULL) begin
                    keys_r[8*wr_idx +: 8] <= rx_byte;
                    key_valid_r[wr_idx]   <= 1'b1;
                    key_count_r           <= key_count_r + 4'd1;
                end
            end
        end
    end

    assign mv.keys_out   = keys_r;
    assign mv.key_valid  = key_valid_r;
    assign mv.key_count  = key_count_r;
    assign mv.move_valid = move_valid_r;

endmodule

// File: tb/tb_ps2_key_collector.sv
// Randomised bench for ps2_key_collector: frames are bit-banged on the PS/2 lines, a queue-based
// key model predicts the buffer, and a monitor pops expected strobe/error events as the DUT emits them.
module tb_ps2_key_collector;

    localparam int          NK   = 4;
    localparam int          TO   = 200;
    localparam int          HALF = 8;
    localparam logic [7:0]  BKSP = 8'h66;
    localparam logic [7:0]  ESC  = 8'h76;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic byte_strobe, frame_err;

    ps2_key_collector_if #(.NUM_KEYS(NK)) mv_if ();

    ps2_key_collector #(
        .NUM_KEYS(NK), .TIMEOUT_CYC(TO), .BKSP_CODE(BKSP), .ESC_CODE(ESC)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .mv(mv_if.master), .byte_strobe(byte_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected event stream: 1 = good byte, 0 = frame error
    bit ev_q[$];
    bit ev_exp;

    // Reference model: the move buffer as a queue of released codes
    logic [7:0] mq[$];
    bit         mbp = 1'b0;

    logic [7:0] pool [11] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B, 8'h15, 8'h1D, 8'h24, 8'h66, 8'h76, 8'h00};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (byte_strobe || frame_err)) begin
            n_cmp++;
            if (ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: strobe=%0b err=%0b want none", byte_strobe, frame_err);
            end else begin
                ev_exp = ev_q.pop_front();
                if (byte_strobe !== ev_exp || frame_err !== !ev_exp) begin
                    n_bad++;
                    $display("FAIL event_kind: strobe=%0b err=%0b want strobe=%0b err=%0b",
                             byte_strobe, frame_err, ev_exp, !ev_exp);
                end
            end
        end
    end

    function automatic void model_apply(input logic [7:0] b);
        if (b == 8'hF0) mbp = 1'b1;
        else if (b == 8'hE0) begin end
        else if (!mbp) begin end
        else begin
            mbp = 1'b0;
            if (b == ESC) mq.delete();
            else if (b == BKSP) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end
            else if (mq.size() < NK) mq.push_back(b);
        end
    endfunction

    task automatic check_state(input string tag);
        logic [8*NK-1:0] ek;
        logic [NK-1:0]   ev;
        ek = '0;
        ev = '0;
        for (int i = 0; i < mq.size(); i++) begin
            ek[8*i +: 8] = mq[i];
            ev[i] = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_count"}, 64'(mv_if.key_count), 64'(mq.size()));
        chk({tag, "_keys"},  64'(mv_if.keys_out),  64'(ek));
        chk({tag, "_valid"}, 64'(mv_if.key_valid), 64'(ev));
        chk({tag, "_move_valid"}, 64'(mv_if.move_valid), 64'(mq.size() == NK));
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        logic par;
        bit   good;
        par = ~^b ^ flip_par;
`ifdef PS2_PARITY_CHECK_EN
        good = !bad_stop && !flip_par;
`else
        good = !bad_stop;
`endif
        ev_q.push_back(good);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
        if (good) model_apply(b);
    endtask

    task automatic release_key(input logic [7:0] code, input string tag);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(code, 1'b0, 1'b0);
        check_state(tag);
    endtask

    task automatic do_ack(input string tag);
        bit was_full;
        bit seen;
        was_full = (mq.size() == NK);
        if (was_full) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = (mv_if.move_valid === 1'b1);
            end
            chk({tag, "_mv_wait"}, 64'(seen), 64'd1);
        end
        @(negedge clk);
        mv_if.move_ack = 1'b1;
        @(negedge clk);
        mv_if.move_ack = 1'b0;
        if (was_full) mq.delete();
        chk({tag, "_count_after"}, 64'(mv_if.key_count), 64'(mq.size()));
        chk({tag, "_mv_after"}, 64'(mv_if.move_valid), 64'd0);
        check_state(tag);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        int r;
        mv_if.move_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_keys", 64'(mv_if.keys_out), 64'd0);
        chk("reset_valid", 64'(mv_if.key_valid), 64'd0);
        chk("reset_count", 64'(mv_if.key_count), 64'd0);
        chk("reset_mv", 64'(mv_if.move_valid), 64'd0);
        chk("reset_strobe", 64'({byte_strobe, frame_err}), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Make then break of A
        send_frame(8'h1C, 1'b0, 1'b0);
        check_state("make_only");
        release_key(8'h1C, "key_a");
        release_key(8'h32, "k2");
        release_key(8'h21, "k3");
        release_key(8'h23, "k4");
        chk("full_keys_const", 64'(mv_if.keys_out), 64'h23_21_32_1C);
        do_ack("ack_full");

        // Backspace and escape
        release_key(8'h15, "e1");
        release_key(8'h1D, "e2");
        release_key(8'h24, "e3");
        release_key(BKSP, "bksp");
        chk("bksp_const", 64'(mv_if.key_valid), 64'b0011);
        release_key(ESC, "esc");
        release_key(BKSP, "bksp_empty");

        // Overfill then backspace
        release_key(8'h1C, "f1");
        release_key(8'h32, "f2");
        release_key(8'h21, "f3");
        release_key(8'h23, "f4");
        release_key(8'h2B, "overfill");
        release_key(BKSP, "bksp_full");
        do_ack("ack_idle");

        // Bad frames
        send_frame(8'h1C, 1'b1, 1'b0);
        check_state("flip_par");
        send_frame(8'h2B, 1'b0, 1'b1);
        check_state("bad_stop");

        // Idle-line edge with data high is not a start bit
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);

        // Timeout after 5 bits
        ev_q.push_back(1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 20) @(negedge clk);
        check_state("timeout");
        release_key(8'h1C, "post_timeout");

        // Randomised traffic
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            code = pool[$urandom_range(0, 10)];
            if (code == 8'h00) code = 8'($urandom);
            case (r)
                0, 1, 2, 3, 4: release_key(code, "rnd_rel");
                5: begin send_frame(code, 1'b0, 1'b0); check_state("rnd_make"); end
                6: begin send_frame(8'hE0, 1'b0, 1'b0); check_state("rnd_e0"); end
                7: begin
                    send_frame(code, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                    check_state("rnd_bad");
                end
                8: do_ack("rnd_ack");
                default: release_key(($urandom_range(0, 1) == 1) ? ESC : BKSP, "rnd_edit");
            endcase
        end

        // Reset during a frame with keys stored
        mq.delete();
        mbp = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(ESC, 1'b0, 1'b0);
        release_key(8'h1C, "pre_rst1");
        release_key(8'h32, "pre_rst2");
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_keys", 64'(mv_if.keys_out), 64'd0);
        chk("midrst_count", 64'(mv_if.key_count), 64'd0);
        chk("midrst_valid", 64'(mv_if.key_valid), 64'd0);
        chk("midrst_pulses", 64'({byte_strobe, frame_err, mv_if.move_valid}), 64'd0);
        rst = 1'b0;
        ps2_data = 1'b1;
        mq.delete();
        mbp = 1'b0;
        repeat (5) @(negedge clk);
        release_key(8'h2B, "post_rst");

        repeat (10) @(negedge clk);
        chk("events_drained", 64'(ev_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_collector.md
Name: ps2_key_collector

Overview:
- Parametrised successor to the team's PS/2 key-capture logic. Runs entirely on the system clock and oversamples the PS/2 clock and data lines.
- Decodes and validates each 11-bit frame, tracks break (F0) sequences, and collects NUM_KEYS released keys into a move buffer.
- Editing: backspace deletes only the last key; escape clears the whole buffer.
- Presents a completed move to the game controller with a valid/ack handshake.

Parameters:
- NUM_KEYS, 4, number of key codes per move (2..8).
- TIMEOUT_CYC, 50000, system clocks with no PS/2 falling edge before a partial frame is aborted.
- BKSP_CODE, 8'h66, scan code that deletes the last stored key.
- ESC_CODE, 8'h76, scan code that clears the whole buffer.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock (asynchronous).
- ps2_data  input  1  raw PS/2 data (asynchronous).
- keys_out  output  8*NUM_KEYS  key slots, flattened; slot i = bits [8i+7:8i].
- key_valid  output  NUM_KEYS  bit i = slot i holds a key.
- key_count  output  4  number of stored keys (0..NUM_KEYS).
- move_valid  output  1  buffer full; move ready.
- move_ack  input  1  controller consumed the move.
- byte_strobe  output  1  one-cycle pulse per accepted byte.
- frame_err  output  1  one-cycle pulse on a bad frame or a timeout.

Behaviour:
- Clocking and reset:
  - One clock, clk; reset is synchronous and active-high (rst).
  - Reset state: all outputs 0, keys_out all zero, both FSMs idle, break_pending=0, timeout counter=0.
- Input sampling:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser, plus one history flop on clk.
  - A falling edge is sync_clk_prev=1 and sync_clk=0. Data is sampled on the falling-edge cycle.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit index 0. An edge with data=1 stays in IDLE with no error.
  - DATA: shift in 8 bits LSB first, then go to PARITY.
  - PARITY: store the parity bit, go to STOP.
  - STOP: stop bit must be 1. If the frame is good, pulse byte_strobe with the byte held. If bad, pulse frame_err. Either way return to IDLE.
  - Timeout counter resets on every falling edge. If it reaches TIMEOUT_CYC outside IDLE: return to IDLE, pulse frame_err, discard the partial byte.
  - Byte latency: 1 clk after the stop-bit edge is synchronised.
- Decode, on byte_strobe:
  - F0: set break_pending.
  - E0: ignored; break_pending is unchanged.
  - Any other byte with break_pending=0 is a make or typematic repeat: ignored.
  - Any other byte with break_pending=1: clear break_pending and act on the released code (below).
- Released-code actions:
  - ESC_CODE: clear all slots, key_valid=0, count=0, move_valid=0.
  - BKSP_CODE: if count>0, zero slot count-1, clear its valid bit, count-1, move_valid=0. If count=0, no effect.
  - Other code, count<NUM_KEYS: write it into slot count, set its valid bit, count+1. When count reaches NUM_KEYS, move_valid=1 on the following clk.
  - Other code, count==NUM_KEYS: ignored (buffer full).
- Handshake:
  - move_valid holds until a clk with move_valid=1 and move_ack=1.
  - The next cycle clears all slots, key_valid, count and move_valid.
  - move_ack while move_valid=0 is ignored.
- Simultaneous events:
  - move_ack handshake and a released-code action in the same clk: the ack clear wins and the key is dropped.
  - rst overrides everything, including a mid-frame reception; the frame FSM restarts in IDLE.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the frame is good only if start=0, stop=1 and the 9 bits (data plus parity) have odd parity. A parity failure discards the byte, pulses frame_err and does not touch break_pending.
- Undefined: the parity bit is sampled but ignored. The frame is good if start=0 and stop=1.

Test Plan:
- Send make 1C, then F0 1C (key A): byte_strobe fires 3 times; slot0=1C, key_valid=0001, count=1, no move_valid.
- Release 1C, 32, 21, 23 in sequence: move_valid=1, keys_out=23_21_32_1C. Assert move_ack for 1 clk: next clk count=0, keys_out=0, move_valid=0.
- Release 3 keys, then release 66: count=2, slot2=00, key_valid=0011. Release 76: count=0, key_valid=0000.
- Fill the buffer, then release a 5th key 2B: still count=4 and slots unchanged. Release 66: move_valid=0, count=3.
- Frame with a flipped parity bit: with PS2_PARITY_CHECK_EN, frame_err pulses and no byte_strobe. Without it, byte_strobe fires. Frame with stop=0: frame_err in both builds.
- Stop ps2_clk after 5 bits for TIMEOUT_CYC+2 clks: frame_err pulses once and the FSM is in IDLE. The next full frame F0 is decoded correctly. Asserting rst mid-frame clears all outputs on the next clk.
